data_sram_resp: RTL and testbench

- Responder end of the pipeline's data-SRAM interface. Sits between EX (request side) and MEM (consumer of rdata).
- Accepts the EX-stage request (en, byte-write enables, address, write data) and returns read data to MEM.
- Read latency is configurable. For latency above 1, it raises a stall request so the pipeline holds the load in MEM until data is valid.
- Byte-writable, word-organised, single-port synchronous memory with registered read output.

---
 rtl/data_sram_resp_if.sv | 28 ++
 rtl/data_sram_resp.sv | 147 ++++++++++++++
 tb/tb_data_sram_resp.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: request/response bundle between the EX/MEM pipeline (master) and the
// data-SRAM responder (slave).
//   en       request valid, sampled on posedge clk
//   wen      byte write enables (0000 with en=1 is a read)
//   addr     byte address (word index taken from addr[ADDR_W+1:2])
//   wdata    lane-aligned store data
//   rdata    registered read data word
//   rvalid   one-cycle pulse when a new read word appears on rdata
//   stallreq high while a multi-cycle read is outstanding
interface data_sram_resp_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stallreq;

    modport master (
        output en, wen, addr, wdata,
        input  rdata, rvalid, stallreq
    );

    modport slave (
        input  en, wen, addr, wdata,
        output rdata, rvalid, stallreq
    );
endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp: responder end of the pipeline data-SRAM interface.
// Byte-writable, word-organised single-port synchronous memory with a registered read
// output and configurable read latency. For RD_LAT > 1 a read parks the FSM in WAIT and
// raises stallreq so the pipeline holds the load in MEM until rdata is valid.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (memory contents are not cleared)
//   bus      data_sram_resp_if.slave: en/wen/addr/wdata in, rdata/rvalid/stallreq out
//   rd_cnt   (DATA_SRAM_STATS_EN only) accepted-read counter
//   wr_cnt   (DATA_SRAM_STATS_EN only) accepted-write counter
// Parameters: ADDR_W word-address width (depth 2**ADDR_W), RD_LAT read latency 1..8.
// Optional feature macro: DATA_SRAM_STATS_EN adds the rd_cnt/wr_cnt statistics ports.
module data_sram_resp #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DATA_SRAM_STATS_EN
    output logic [31:0]        rd_cnt,
    output logic [31:0]        wr_cnt,
`endif
    data_sram_resp_if.slave    bus
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
        $error("data_sram_resp: RD_LAT must be in 1..8");
    end

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic [31:0]       mem_q [Depth];

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              accept_rd;
    logic              accept_wr;
    logic              rd_fire;

    // Upper address bits and the byte offset do not select a word.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

    assign idx       = bus.addr[ADDR_W+1:2];
    // Requests arriving while in WAIT are dropped; the stalled pipeline re-presents them.
    assign accept_rd = !rst && (state_q == StIdle) && bus.en && (bus.wen == 4'b0000);
    assign accept_wr = !rst && (state_q == StIdle) && bus.en && (bus.wen != 4'b0000);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept_rd && (RD_LAT > 1)) begin
                    state_d = StWait;
                    cnt_d   = 3'(RD_LAT - 1);
                    idx_d   = idx;
                end
            end
            StWait: begin
                if (cnt_q == 3'd1) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: the read word is captured into rdata_q on the edge the data becomes due,
    // using the latched index in WAIT rather than whatever is on addr now.
    always_comb begin
        rd_fire  = ((state_q == StIdle) && accept_rd && (RD_LAT == 1)) ||
                   ((state_q == StWait) && (cnt_q == 3'd1));
        rd_idx   = (state_q == StWait) ? idx_q : idx;
        rdata_d  = rd_fire ? mem_q[rd_idx] : rdata_q;
        rvalid_d = rd_fire;
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.stallreq = (state_q == StWait);

    // Memory array: byte-lane writes, never reset.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wen[b]) begin
                    mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef DATA_SRAM_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + {31'd0, accept_rd};
        wr_cnt_d = wr_cnt_q + {31'd0, accept_wr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (RD_LAT = 1, 3, 4) share one stimulus stream.
// A per-instance reference model (word array plus a "data due in N edges" countdown) predicts
// rdata/rvalid/stallreq every cycle; directed steps add explicit value checks.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    data_sram_resp_if if_l1 ();
    data_sram_resp_if if_l3 ();
    data_sram_resp_if if_l4 ();

    assign if_l1.en = en;  assign if_l1.wen = wen;  assign if_l1.addr = addr;  assign if_l1.wdata = wdata;
    assign if_l3.en = en;  assign if_l3.wen = wen;  assign if_l3.addr = addr;  assign if_l3.wdata = wdata;
    assign if_l4.en = en;  assign if_l4.wen = wen;  assign if_l4.addr = addr;  assign if_l4.wdata = wdata;

    logic [31:0] rd_obs [3];
    logic        rv_obs [3];
    logic        st_obs [3];
    assign rd_obs[0] = if_l1.rdata;  assign rv_obs[0] = if_l1.rvalid;  assign st_obs[0] = if_l1.stallreq;
    assign rd_obs[1] = if_l3.rdata;  assign rv_obs[1] = if_l3.rvalid;  assign st_obs[1] = if_l3.stallreq;
    assign rd_obs[2] = if_l4.rdata;  assign rv_obs[2] = if_l4.rvalid;  assign st_obs[2] = if_l4.stallreq;

`ifdef DATA_SRAM_STATS_EN
    logic [31:0] rdc_obs [3];
    logic [31:0] wrc_obs [3];
    data_sram_resp #(.ADDR_W(10), .RD_LAT(1)) u_l1 (.clk(clk), .rst(rst), .rd_cnt(rdc_obs[0]),
                                                    .wr_cnt(wrc_obs[0]), .bus(if_l1.slave));
    data_sram_resp #(.ADDR_W(10), .RD_LAT(3)) u_l3 (.clk(clk), .rst(rst), .rd_cnt(rdc_obs[1]),
                                                    .wr_cnt(wrc_obs[1]), .bus(if_l3.slave));
    data_sram_resp #(.ADDR_W(10), .RD_LAT(4)) u_l4 (.clk(clk), .rst(rst), .rd_cnt(rdc_obs[2]),
                                                    .wr_cnt(wrc_obs[2]), .bus(if_l4.slave));
`else
    data_sram_resp #(.ADDR_W(10), .RD_LAT(1)) u_l1 (.clk(clk), .rst(rst), .bus(if_l1.slave));
    data_sram_resp #(.ADDR_W(10), .RD_LAT(3)) u_l3 (.clk(clk), .rst(rst), .bus(if_l3.slave));
    data_sram_resp #(.ADDR_W(10), .RD_LAT(4)) u_l4 (.clk(clk), .rst(rst), .bus(if_l4.slave));
`endif

    // Reference model state
    int          lat [3] = '{1, 3, 4};
    logic [31:0] mmem [3][1024];
    bit          busy [3];
    int          rem [3];
    int          pidx [3];
    logic [31:0] e_rdata [3];
    logic        e_rvalid [3];
    logic        e_stall [3];
    logic [31:0] e_rd [3];
    logic [31:0] e_wr [3];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int ix;
        ix = int'(addr[11:2]);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                e_rdata[k]  = 32'd0;
                e_rvalid[k] = 1'b0;
                busy[k]     = 1'b0;
                e_rd[k]     = 32'd0;
                e_wr[k]     = 32'd0;
            end else begin
                e_rvalid[k] = 1'b0;
                if (busy[k]) begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        e_rdata[k]  = mmem[k][pidx[k]];
                        e_rvalid[k] = 1'b1;
                        busy[k]     = 1'b0;
                    end
                end else if (en) begin
                    if (wen != 4'b0000) begin
                        for (int b = 0; b < 4; b++)
                            if (wen[b]) mmem[k][ix][8*b +: 8] = wdata[8*b +: 8];
                        e_wr[k]++;
                    end else begin
                        e_rd[k]++;
                        if (lat[k] == 1) begin
                            e_rdata[k]  = mmem[k][ix];
                            e_rvalid[k] = 1'b1;
                        end else begin
                            busy[k] = 1'b1;
                            rem[k]  = lat[k] - 1;
                            pidx[k] = ix;
                        end
                    end
                end
            end
            e_stall[k] = busy[k];
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lat%0d rdata", lat[k]), rd_obs[k], e_rdata[k]);
            check($sformatf("lat%0d rvalid", lat[k]), {31'd0, rv_obs[k]}, {31'd0, e_rvalid[k]});
            check($sformatf("lat%0d stallreq", lat[k]), {31'd0, st_obs[k]}, {31'd0, e_stall[k]});
`ifdef DATA_SRAM_STATS_EN
            check($sformatf("lat%0d rd_cnt", lat[k]), rdc_obs[k], e_rd[k]);
            check($sformatf("lat%0d wr_cnt", lat[k]), wrc_obs[k], e_wr[k]);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        en = 1'b1; wen = w; addr = a; wdata = d;
        step();
        en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        en = 1'b1; wen = 4'b0000; addr = a;
        step();
        en = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; en = 1'b0; wen = 4'b0; addr = 32'd0; wdata = 32'd0;
        step();
        step();
        check("reset rdata l4", rd_obs[2], 32'd0);
        rst = 1'b0;

        // Preload the 16 words the bench works in.
        for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF);
        wr(32'h30, 32'hC0FFEE01, 4'hF);

        // Write then read; a write presented during WAIT only lands in the RD_LAT=1 instance.
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        rd(32'h10);
        check("t1 lat1 rdata", rd_obs[0], 32'hDEADBEEF);
        check("t1 lat1 rvalid", {31'd0, rv_obs[0]}, 32'd1);
        check("t1 lat3 stall", {31'd0, st_obs[1]}, 32'd1);
        en = 1'b1; wen = 4'hF; addr = 32'h10; wdata = 32'h0BAD0BAD;
        step();
        en = 1'b0;
        step();
        check("t3 lat3 rdata", rd_obs[1], 32'hDEADBEEF);
        check("t3 lat3 stall dropped", {31'd0, st_obs[1]}, 32'd0);
        step();
        check("t3 lat4 rdata", rd_obs[2], 32'hDEADBEEF);
        rd(32'h10);
        idle(4);
        check("wait write dropped l3", rd_obs[1], 32'hDEADBEEF);
        check("idle write applied l1", rd_obs[0], 32'h0BAD0BAD);

        // Byte lanes.
        wr(32'h20, 32'h11223344, 4'hF);
        wr(32'h20, 32'h000000AA, 4'b0001);
        wr(32'h20, 32'hBB000000, 4'b1000);
        rd(32'h20);
        check("lanes l1", rd_obs[0], 32'hBB2233AA);
        idle(4);
        check("lanes l4", rd_obs[2], 32'hBB2233AA);

        // Index wrap and ignored byte offset.
        wr(32'h00001004, 32'h5A5A5A5A, 4'hF);
        rd(32'h00000004);
        check("wrap l1", rd_obs[0], 32'h5A5A5A5A);
        idle(4);
        rd(32'h00000007);
        idle(4);
        check("offset l3", rd_obs[1], 32'h5A5A5A5A);

        // Reset in the second WAIT cycle aborts the read.
        rd(32'h30);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort l4 stall", {31'd0, st_obs[2]}, 32'd0);
        check("abort l4 rdata", rd_obs[2], 32'd0);
        idle(4);
        rd(32'h30);
        idle(4);
        check("after abort l4", rd_obs[2], 32'hC0FFEE01);

        // Random traffic within the preloaded window, occasional reset.
        for (int n = 0; n < 400; n++) begin
            a = $urandom;
            a[11:6] = 6'd0;
            addr  = a;
            wdata = $urandom;
            wen   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            en    = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 60) == 0);
            if (rst) en = 1'b0;
            step();
        end
        rst = 1'b0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
